// File: rtl/base_ram_ctrl.sv
// BaseRAM sequencer/arbiter: IDLE -> SETUP -> ACCESS(xWAIT_CYCLES) -> DONE per transaction.
// Define BASE_RAM_CTRL_RR_EN for round-robin arbitration; default is LSU priority with a starvation guard.
module base_ram_ctrl #(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  input  logic [31:0] ifu_wdata_i,
  input  logic [3:0]  ifu_be_n_i,
  input  logic        ifu_re_n_i,
  input  logic        ifu_we_n_i,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_resp_o,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_be_n_i,
  input  logic        lsu_re_n_i,
  input  logic        lsu_we_n_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_o,
  output logic [31:0] base_ram_wdata,
  input  logic [31:0] base_ram_rdata,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;
  typedef enum logic [1:0] {OP_NULL, OP_READ, OP_WRITE} op_e;

  state_e      state_q;
  op_e         op_q;
  logic [3:0]  wait_q;
  logic        gnt_lsu_q;
  logic [31:0] rdata_q;
  logic        resp_ifu_q, resp_lsu_q;
  logic [19:0] addr_q;
  logic [3:0]  be_n_q;
  logic [31:0] wdata_q;
  logic        ce_n_q, oe_n_q, we_n_q;

  logic        gnt_lsu_d;
  op_e         op_d;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be_n;
  logic        sel_re_n, sel_we_n;
  logic        any_req;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_addr_i[31:22], ifu_addr_i[1:0],
                              lsu_addr_i[31:22], lsu_addr_i[1:0]};

  assign any_req = ifu_req_i | lsu_req_i;

`ifdef BASE_RAM_CTRL_RR_EN
  // Holds the requester that wins the next tie, so IFU goes first after reset.
  logic prio_ifu_q;
  logic prio_ifu_d;
`else
  logic [3:0] streak_q;
  logic [3:0] streak_d;
`endif

  always_comb begin
    gnt_lsu_d = lsu_req_i;
`ifdef BASE_RAM_CTRL_RR_EN
    if (lsu_req_i && ifu_req_i) gnt_lsu_d = ~prio_ifu_q;
    prio_ifu_d = gnt_lsu_d;
`else
    if (lsu_req_i && ifu_req_i) gnt_lsu_d = (streak_q != 4'(MAX_LSU_STREAK));
    streak_d = (gnt_lsu_d && ifu_req_i) ? streak_q + 4'd1 : '0;
`endif
    sel_addr  = gnt_lsu_d ? lsu_addr_i  : ifu_addr_i;
    sel_wdata = gnt_lsu_d ? lsu_wdata_i : ifu_wdata_i;
    sel_be_n  = gnt_lsu_d ? lsu_be_n_i  : ifu_be_n_i;
    sel_re_n  = gnt_lsu_d ? lsu_re_n_i  : ifu_re_n_i;
    sel_we_n  = gnt_lsu_d ? lsu_we_n_i  : ifu_we_n_i;
    if (!sel_we_n)      op_d = OP_WRITE;
    else if (!sel_re_n) op_d = OP_READ;
    else                op_d = OP_NULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NULL;
      wait_q     <= '0;
      gnt_lsu_q  <= 1'b0;
      rdata_q    <= '0;
      resp_ifu_q <= 1'b0;
      resp_lsu_q <= 1'b0;
      addr_q     <= '0;
      be_n_q     <= '1;
      wdata_q    <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
`ifdef BASE_RAM_CTRL_RR_EN
      prio_ifu_q <= 1'b1;
`else
      streak_q   <= '0;
`endif
    end else begin
      resp_ifu_q <= 1'b0;
      resp_lsu_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q   <= S_SETUP;
            gnt_lsu_q <= gnt_lsu_d;
            op_q      <= op_d;
            addr_q    <= sel_addr[21:2];
            be_n_q    <= sel_be_n;
            wdata_q   <= sel_wdata;
            ce_n_q    <= 1'b0;
            oe_n_q    <= (op_d != OP_READ);
            we_n_q    <= 1'b1;
`ifdef BASE_RAM_CTRL_RR_EN
            prio_ifu_q <= prio_ifu_d;
`else
            streak_q   <= streak_d;
`endif
          end
        end
        S_SETUP: begin
          wait_q  <= 4'(WAIT_CYCLES - 1);
          we_n_q  <= (op_q != OP_WRITE);
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (wait_q == '0) begin
            // Non-read ops clear the shared read register so both rdata ports show zero.
            rdata_q    <= (op_q == OP_READ) ? base_ram_rdata : '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            resp_ifu_q <= ~gnt_lsu_q;
            resp_lsu_q <= gnt_lsu_q;
            state_q    <= S_DONE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_rdata_o    = rdata_q;
  assign lsu_rdata_o    = rdata_q;
  assign ifu_resp_o     = resp_ifu_q;
  assign lsu_resp_o     = resp_lsu_q;
  assign base_ram_wdata = wdata_q;
  assign base_ram_addr  = addr_q;
  assign base_ram_be_n  = be_n_q;
  assign base_ram_ce_n  = ce_n_q;
  assign base_ram_oe_n  = oe_n_q;
  assign base_ram_we_n  = we_n_q;

endmodule

// File: tb/tb_base_ram_ctrl.sv
// Self-checking bench for base_ram_ctrl (default LSU-priority build) with a cycle-indexed transaction model.
module tb_base_ram_ctrl;
  localparam int unsigned WC = 3;
  localparam int unsigned MS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, lsu_req;
  logic [31:0] ifu_addr, lsu_addr, ifu_wdata, lsu_wdata;
  logic [3:0]  ifu_be_n, lsu_be_n;
  logic        ifu_re_n, ifu_we_n, lsu_re_n, lsu_we_n;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        ifu_resp, lsu_resp;
  logic [31:0] ram_wdata, ram_rdata;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  int checks   = 0;
  int failures = 0;
  int streak_m = 0;

  always #5 clk = ~clk;

  base_ram_ctrl #(.WAIT_CYCLES(WC), .MAX_LSU_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_wdata_i(ifu_wdata),
    .ifu_be_n_i(ifu_be_n), .ifu_re_n_i(ifu_re_n), .ifu_we_n_i(ifu_we_n),
    .ifu_rdata_o(ifu_rdata), .ifu_resp_o(ifu_resp),
    .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_be_n_i(lsu_be_n), .lsu_re_n_i(lsu_re_n), .lsu_we_n_i(lsu_we_n),
    .lsu_rdata_o(lsu_rdata), .lsu_resp_o(lsu_resp),
    .base_ram_wdata(ram_wdata), .base_ram_rdata(ram_rdata),
    .base_ram_addr(ram_addr), .base_ram_be_n(ram_be_n),
    .base_ram_ce_n(ram_ce_n), .base_ram_oe_n(ram_oe_n), .base_ram_we_n(ram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with at least one request presented; ends in the following IDLE cycle.
  task automatic do_txn(input bit fix, input logic [31:0] fix_val);
    bit          lsu_win, is_rd, is_wr;
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  be;
    if (lsu_req && ifu_req) lsu_win = (streak_m != int'(MS));
    else                    lsu_win = lsu_req;
    if (lsu_win && ifu_req) streak_m++;
    else                    streak_m = 0;
    a     = lsu_win ? lsu_addr  : ifu_addr;
    wd    = lsu_win ? lsu_wdata : ifu_wdata;
    be    = lsu_win ? lsu_be_n  : ifu_be_n;
    is_wr = lsu_win ? !lsu_we_n : !ifu_we_n;
    is_rd = !is_wr && (lsu_win ? !lsu_re_n : !ifu_re_n);
    exp_rd = '0;
    for (int k = 1; k <= 2 + int'(WC); k++) begin
      step();
      ram_rdata = (fix && k == 1 + int'(WC)) ? fix_val : $urandom();
      if (k == 1 + int'(WC) && is_rd) exp_rd = ram_rdata;
      check("ce_n", ram_ce_n, (k < 2 + int'(WC)) ? 0 : 1);
      check("oe_n", ram_oe_n, (k < 2 + int'(WC) && is_rd) ? 0 : 1);
      check("we_n", ram_we_n, (k >= 2 && k <= 1 + int'(WC) && is_wr) ? 0 : 1);
      check("addr", ram_addr, a[21:2]);
      check("be_n", ram_be_n, be);
      check("wdata", ram_wdata, wd);
      check("ifu_resp", ifu_resp, (k == 2 + int'(WC) && !lsu_win) ? 1 : 0);
      check("lsu_resp", lsu_resp, (k == 2 + int'(WC) && lsu_win) ? 1 : 0);
      if (k == 2 + int'(WC)) begin
        check("ifu_rdata", ifu_rdata, exp_rd);
        check("lsu_rdata", lsu_rdata, exp_rd);
      end
    end
    step();
    check("idle_ce_n", ram_ce_n, 1);
    check("idle_resp", {ifu_resp, lsu_resp}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_req = 0; lsu_req = 0;
    ifu_addr = '0; lsu_addr = '0; ifu_wdata = '0; lsu_wdata = '0;
    ifu_be_n = '1; lsu_be_n = '1;
    ifu_re_n = 1; ifu_we_n = 1; lsu_re_n = 1; lsu_we_n = 1;
    ram_rdata = '0;
    step(); step();
    check("rst_ce_n", ram_ce_n, 1);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_we_n", ram_we_n, 1);
    check("rst_be_n", ram_be_n, 4'hF);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rdata", ifu_rdata, 0);
    check("rst_resp", {ifu_resp, lsu_resp}, 0);
    rst = 1'b0;

    step(); step();
    check("noreq_ce_n", ram_ce_n, 1);
    check("noreq_resp", {ifu_resp, lsu_resp}, 0);

    ifu_req = 1; ifu_addr = 32'h8000_0010; ifu_re_n = 0; ifu_we_n = 1; ifu_be_n = 4'h0;
    do_txn(1, 32'h1234_5678);
    ifu_req = 0;

    lsu_req = 1; lsu_addr = 32'h8000_0020; lsu_wdata = 32'hCAFE_F00D;
    lsu_be_n = 4'b1100; lsu_re_n = 1; lsu_we_n = 0;
    do_txn(0, '0);
    lsu_re_n = 0; lsu_we_n = 0; lsu_wdata = 32'h0BAD_BEEF;
    do_txn(0, '0);
    lsu_req = 0;

    ifu_req = 1; ifu_re_n = 1; ifu_we_n = 1; ifu_addr = 32'h8012_3458;
    do_txn(0, '0);

    ifu_re_n = 0; lsu_req = 1; lsu_re_n = 0; lsu_we_n = 1;
    for (int i = 0; i < 10; i++) do_txn(0, '0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(1, 3));
      ifu_req = pat[0]; lsu_req = pat[1];
      ifu_addr = $urandom(); lsu_addr = $urandom();
      ifu_wdata = $urandom(); lsu_wdata = $urandom();
      ifu_be_n = 4'($urandom()); lsu_be_n = 4'($urandom());
      ifu_re_n = 1'($urandom()); ifu_we_n = 1'($urandom());
      lsu_re_n = 1'($urandom()); lsu_we_n = 1'($urandom());
      do_txn(0, '0);
    end

    ifu_req = 0; lsu_req = 1; lsu_we_n = 0; lsu_re_n = 1;
    lsu_addr = 32'h8000_0100; lsu_wdata = 32'h5555_AAAA; lsu_be_n = 4'h0;
    step(); step();
    check("pre_rst_we_n", ram_we_n, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ce_n", ram_ce_n, 1);
    check("mid_rst_we_n", ram_we_n, 1);
    check("mid_rst_resp", {ifu_resp, lsu_resp}, 0);
    step();
    check("held_rst_resp", {ifu_resp, lsu_resp}, 0);
    rst = 1'b0;
    streak_m = 0;
    do_txn(0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/base_ram_ctrl.md
# base_ram_ctrl

Registered, multi-cycle sequencer and arbiter for the BaseRAM SRAM port, shared between the instruction-fetch (IFU) and load/store (LSU) requesters. It replaces direct combinational SRAM driving with an explicit SETUP/ACCESS/DONE cycle sequence that has programmable wait states. It sits between the CPU memory request ports and the BaseRAM pins. Arbitration is LSU-priority with a starvation guard, or strict round-robin when configured.

## Interface
Parameters:
- WAIT_CYCLES, 1, number of ACCESS cycles per transaction; legal range 1..15.
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU waits; legal range 1..15. Used only in fixed-priority mode.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_i  in  1  IFU request level; held until ifu_resp_o is seen.
- ifu_addr_i  in  32  IFU byte address; bits [21:2] are used.
- ifu_wdata_i  in  32  IFU write data.
- ifu_be_n_i  in  4  IFU byte enables, active-low.
- ifu_re_n_i  in  1  IFU read strobe, active-low.
- ifu_we_n_i  in  1  IFU write strobe, active-low.
- ifu_rdata_o  out  32  read data; valid only while ifu_resp_o=1.
- ifu_resp_o  out  1  one-cycle completion pulse.
- lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_be_n_i, lsu_re_n_i, lsu_we_n_i, lsu_rdata_o, lsu_resp_o: same directions, widths and meanings as the IFU ports.
- base_ram_wdata  out  32  registered write data.
- base_ram_rdata  in  32  SRAM read data.
- base_ram_addr  out  20  registered word address.
- base_ram_be_n  out  4  registered byte enables.
- base_ram_ce_n  out  1  chip select, active-low.
- base_ram_oe_n  out  1  output enable, active-low.
- base_ram_we_n  out  1  write enable, active-low.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: sample both req inputs. If any request is present, grant one requester, latch its addr[21:2], be_n, wdata and op, then go to SETUP. If no request is present, stay in IDLE.
- Op decode:
  - we_n=0 selects WRITE; this applies even when re_n=0 as well.
  - Otherwise re_n=0 selects READ.
  - Otherwise the transaction is NULL: it still runs the full sequence, drives no strobes and returns resp.
- SETUP:
  - ce_n=0; addr and be_n are driven.
  - oe_n=0 for READ; we_n=1 for all ops.
  - Wait-state counter loads WAIT_CYCLES-1. Next state is ACCESS.
- ACCESS:
  - ce_n=0; oe_n=0 for READ; we_n=0 for WRITE only.
  - Counter decrements each cycle. When the counter is 0, latch base_ram_rdata into the shared read register if the op is READ, then go to DONE.
- DONE:
  - ce_n=1, oe_n=1, we_n=1; addr, be_n and wdata are held; write hold time is one cycle.
  - The granted requester's resp_o=1; rdata_o is driven from the read register. Next state is IDLE.
- The non-granted requester's resp_o is always 0. Both rdata_o ports carry the read register, and 32'h0 for WRITE and NULL ops.
- Arbitration, fixed-priority mode:
  - LSU wins simultaneous requests, unless the streak counter equals MAX_LSU_STREAK and ifu_req_i=1; in that case IFU wins.
  - Streak counter increments on each LSU grant made while ifu_req_i=1. It clears on any IFU grant, and on any LSU grant made while ifu_req_i=0.
- A request line that is still high in the IDLE cycle after resp is treated as a new transaction.

## Timing
- Latency: request sampled in IDLE at cycle 0; resp at cycle 2+WAIT_CYCLES (3 cycles with the default).
- Throughput: one transaction per 3+WAIT_CYCLES cycles, because of the mandatory IDLE bubble.
- Requester inputs must stay stable from req rise until resp; only the IDLE-cycle sample is used.
- Reset values (asynchronous, immediate):
  - FSM=IDLE, ce_n=1, oe_n=1, we_n=1, be_n=4'hF, addr=0, wdata=0.
  - Read register=0, both resp=0, streak counter=0, round-robin pointer=IFU.
- Reset mid-transaction aborts at once. No resp is issued, strobes are released within the reset assertion, and the requester reissues the transaction.
- A request arriving in SETUP, ACCESS or DONE waits; it is evaluated in the next IDLE.

## Configuration
- BASE_RAM_CTRL_RR_EN defined: strict round-robin arbitration.
  - On a simultaneous request, the requester other than the last-granted one wins.
  - The pointer updates on every grant. MAX_LSU_STREAK and the streak counter are not implemented.
- BASE_RAM_CTRL_RR_EN undefined: LSU fixed priority with the starvation guard described under Operation.

## Test plan
- Single IFU read, addr 0x8000_0010, WAIT_CYCLES=1, SRAM returns 0x1234_5678 -> base_ram_addr=0x00004 with ce_n/oe_n=0 in cycles 1-2; ifu_resp_o=1 with ifu_rdata_o=0x1234_5678 at cycle 3; lsu_resp_o stays 0.
- LSU write, addr 0x8000_0020, data 0xCAFE_F00D, be_n=4'b1100 -> we_n=0 only in the ACCESS cycle, wdata and be_n held through DONE, lsu_resp_o at cycle 3, oe_n stays 1.
- Both requesters held continuously, fixed priority, MAX_LSU_STREAK=4 -> grant order LSU×4, IFU, LSU×4, IFU. With BASE_RAM_CTRL_RR_EN defined -> IFU, LSU, IFU, LSU... starting from IFU after reset.
- WAIT_CYCLES=3, read -> ACCESS lasts 3 cycles; rdata is sampled in the 3rd ACCESS cycle only (changing base_ram_rdata earlier has no effect); resp at cycle 5.
- re_n=0 and we_n=0 together -> WRITE performed with oe_n=1. re_n=1 and we_n=1 -> no strobes, but resp still arrives at cycle 2+WAIT_CYCLES with rdata=0.
- rst asserted during ACCESS of a write -> we_n and ce_n go to 1 immediately, no resp is issued; after release the FSM is in IDLE and a held req is serviced from cycle 0.
